// File: rtl/fpu_mul_seq.sv
// Iterative radix-2 significand multiplier (one multiplier bit per cycle) with
// post-normalization into the {hidden, frac, G, R, S} rounder format.
module fpu_mul_seq #(
  parameter int SIG_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mul_start,
  input  logic [8:0]       preNorm_exp,
  input  logic             is_exp_underFlow,
  input  logic [SIG_W-1:0] sig_A,
  input  logic [SIG_W-1:0] sig_B,
  output logic [26:0]      mul_proNorm_sig,
  output logic [7:0]       mul_proNorm_exp,
  output logic             mul_rdy,
  output logic             OF_from_proNorm,
  output logic             UF_from_proNorm
);

  localparam int PW = 2 * SIG_W;
  localparam int CW = $clog2(SIG_W);

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t            state, state_nxt;
  logic [SIG_W-1:0]  a_q, b_q;
  logic [8:0]        exp_q;
  logic              ufl_q;
  logic [PW-1:0]     p_q;
  logic [CW-1:0]     cnt_q;

  logic signed [10:0] e_ext, e_nrm, sh_r, lz, lim;
  logic [PW-1:0]      p_sh;
  logic [26:0]        sig_n, sig_sh;
  logic [7:0]         exp_n;
  logic               of_n, uf_n, lost;

  function automatic logic [10:0] lzc(input logic [PW-2:0] v);
    logic [10:0] n;
    n = 11'(PW - 1);
    for (int i = 0; i < PW - 1; i++) begin
      if (v[i]) n = 11'(PW - 2 - i);
    end
    return n;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mul_start) state_nxt = MUL;
      MUL:     if (cnt_q == CW'(SIG_W - 1)) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mul_rdy = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q   <= '0;
      b_q   <= '0;
      exp_q <= '0;
      ufl_q <= 1'b0;
      p_q   <= '0;
      cnt_q <= '0;
    end else begin
      case (state)
        IDLE: if (mul_start) begin
          a_q   <= sig_A;
          b_q   <= sig_B;
          exp_q <= preNorm_exp;
          ufl_q <= is_exp_underFlow;
          p_q   <= '0;
          cnt_q <= '0;
        end
        MUL: begin
          if (b_q[cnt_q]) p_q <= p_q + ({{SIG_W{1'b0}}, a_q} << cnt_q);
          cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // exp_q is only two's complement when the underflow flag marks it non-positive
  always_comb begin
    e_ext  = ufl_q ? {{2{exp_q[8]}}, exp_q} : {2'b00, exp_q};
    e_nrm  = e_ext;
    lz     = lzc(p_q[PW-2:0]);
    lim    = '0;
    sh_r   = '0;
    p_sh   = p_q;
    sig_n  = '0;
    sig_sh = '0;
    exp_n  = '0;
    of_n   = 1'b0;
    uf_n   = 1'b0;
    lost   = 1'b0;

    if (p_q[PW-1]) begin
      sig_n = {p_q[PW-1 -: 26], |p_q[PW-27:0]};
      e_nrm = e_ext + 11'sd1;
    end else begin
      if (!p_q[PW-2]) begin
        // denormal operand: normalize, but never below the minimum exponent
        if (e_ext > 11'sd1) lim = (e_ext - 11'sd1 < lz) ? e_ext - 11'sd1 : lz;
        p_sh  = p_q << lim;
        e_nrm = e_ext - lz;
        if (e_nrm < 11'sd1) begin
          e_nrm = '0;
          uf_n  = 1'b1;
        end
      end
      sig_n = {p_sh[PW-2 -: 26], |p_sh[PW-28:0]};
    end

    if (ufl_q || e_nrm <= 11'sd0) begin
      sh_r = 11'sd1 - e_nrm;
      if (sh_r >= 11'sd27) begin
        sig_n = {26'b0, |sig_n};
      end else if (sh_r > 11'sd0) begin
        lost   = |(sig_n & ((27'd1 << sh_r) - 27'd1));
        sig_sh = sig_n >> sh_r;
        sig_n  = {sig_sh[26:1], sig_sh[0] | lost};
      end
      exp_n = sig_n[26] ? 8'd1 : 8'd0;
      uf_n  = ~sig_n[26];
    end else begin
      exp_n = e_nrm[7:0];
      of_n  = (e_nrm > 11'sd254);
    end

    if (p_q == '0) begin
      sig_n = '0;
      exp_n = '0;
      of_n  = 1'b0;
      uf_n  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mul_proNorm_sig <= '0;
      mul_proNorm_exp <= '0;
      OF_from_proNorm <= 1'b0;
      UF_from_proNorm <= 1'b0;
    end else if (state == NORM) begin
      mul_proNorm_sig <= sig_n;
      mul_proNorm_exp <= exp_n;
      OF_from_proNorm <= of_n;
      UF_from_proNorm <= uf_n;
    end
  end

endmodule

// File: tb/tb_fpu_mul_seq.sv
// Scoreboard bench for fpu_mul_seq: directed corner cases, control hazards, random operands.
module tb_fpu_mul_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mul_start = 1'b0;
  logic [8:0]  preNorm_exp = '0;
  logic        is_exp_underFlow = 1'b0;
  logic [23:0] sig_A = '0;
  logic [23:0] sig_B = '0;
  logic [26:0] mul_proNorm_sig;
  logic [7:0]  mul_proNorm_exp;
  logic        mul_rdy;
  logic        OF_from_proNorm;
  logic        UF_from_proNorm;

  typedef struct packed {
    logic [26:0] sig;
    logic [7:0]  ex;
    logic        of;
    logic        uf;
  } res_t;

  res_t sb[$];
  res_t last_res = '0;
  res_t mon_r;
  int   n_chk = 0;
  int   n_bad = 0;
  int   n_ops = 0;
  int   n_rdy = 0;

  fpu_mul_seq #(.SIG_W(24)) dut (
    .clk              (clk),
    .reset            (reset),
    .mul_start        (mul_start),
    .preNorm_exp      (preNorm_exp),
    .is_exp_underFlow (is_exp_underFlow),
    .sig_A            (sig_A),
    .sig_B            (sig_B),
    .mul_proNorm_sig  (mul_proNorm_sig),
    .mul_proNorm_exp  (mul_proNorm_exp),
    .mul_rdy          (mul_rdy),
    .OF_from_proNorm  (OF_from_proNorm),
    .UF_from_proNorm  (UF_from_proNorm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic res_t mk(input logic [26:0] sig, input logic [7:0] ex, input logic of, input logic uf);
    res_t r;
    r.sig = sig; r.ex = ex; r.of = of; r.uf = uf;
    return r;
  endfunction

  function automatic res_t model(input logic [23:0] a, input logic [23:0] b,
                                 input logic [8:0] e9, input logic f);
    res_t        r;
    logic [47:0] p, ps;
    logic [26:0] sg;
    int          e, en, z, lim, s;
    logic        lost;
    r = '0;
    p = 48'(a) * 48'(b);
    if (p == 48'd0) return r;
    e = int'(e9);
    if (f && e9[8]) e -= 512;
    if (p[47]) begin
      sg = {p[47:22], |p[21:0]};
      en = e + 1;
    end else begin
      z = 0;
      while (!p[46 - z]) z++;
      lim = (z < e - 1) ? z : e - 1;
      if (lim < 0) lim = 0;
      ps = p << lim;
      sg = {ps[46:21], |ps[20:0]};
      en = (z == 0) ? e : e - z;
      if (z > 0 && en < 1) en = 0;
    end
    if (f || en <= 0) begin
      s = 1 - en;
      if (s >= 27) begin
        sg = {26'd0, |sg};
      end else if (s > 0) begin
        lost = 1'b0;
        for (int i = 0; i < s; i++) lost |= sg[i];
        sg = sg >> s;
        sg[0] = sg[0] | lost;
      end
      r.sig = sg;
      r.ex  = sg[26] ? 8'd1 : 8'd0;
      r.uf  = ~sg[26];
    end else begin
      r.sig = sg;
      r.ex  = en[7:0];
      r.of  = (en > 254);
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (mul_rdy) begin
      n_rdy++;
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_r    = sb.pop_front();
        last_res = mon_r;
        chk("sig", 32'(mul_proNorm_sig), 32'(mon_r.sig));
        chk("exp", 32'(mul_proNorm_exp), 32'(mon_r.ex));
        chk("of",  32'(OF_from_proNorm), 32'(mon_r.of));
        chk("uf",  32'(UF_from_proNorm), 32'(mon_r.uf));
      end
    end
  end

  task automatic run_op(input logic [23:0] a, input logic [23:0] b, input logic [8:0] e9,
                        input logic f, input res_t want, input int glitch, input bit start_in_done);
    int cyc;
    @(posedge clk); #1;
    sig_A = a; sig_B = b; preNorm_exp = e9; is_exp_underFlow = f;
    mul_start = 1'b1;
    sb.push_back(want);
    n_ops++;
    @(posedge clk); #1;
    mul_start = 1'b0;
    sig_A = 24'h5A5A5A; sig_B = 24'hA5A5A5; preNorm_exp = 9'h0AA; is_exp_underFlow = ~f;
    cyc = 1;
    while (!mul_rdy && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      mul_start = (cyc == glitch);
    end
    mul_start = 1'b0;
    chk("latency", 32'(cyc), 32'd26);
    if (start_in_done) begin
      mul_start = 1'b1;
      @(posedge clk); #1;
      mul_start = 1'b0;
    end
  endtask

  task automatic run_m(input logic [23:0] a, input logic [23:0] b, input logic [8:0] e9, input logic f);
    run_op(a, b, e9, f, model(a, b, e9, f), 0, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sig", 32'(mul_proNorm_sig), 32'd0);
    chk("rst_exp", 32'(mul_proNorm_exp), 32'd0);
    chk("rst_of",  32'(OF_from_proNorm), 32'd0);
    chk("rst_uf",  32'(UF_from_proNorm), 32'd0);
    chk("rst_rdy", 32'(mul_rdy), 32'd0);
    reset = 1'b1;

    run_op(24'h800000, 24'h800000, 9'd127,  1'b0, mk(27'h4000000, 8'd127, 1'b0, 1'b0), 0, 1'b0);
    run_op(24'hC00000, 24'hC00000, 9'd127,  1'b0, mk(27'h4800000, 8'd128, 1'b0, 1'b0), 0, 1'b0);
    run_op(24'hC00000, 24'hC00000, 9'd254,  1'b0, mk(27'h4800000, 8'd255, 1'b1, 1'b0), 0, 1'b0);
    run_op(24'h800000, 24'h800000, 9'h1FF,  1'b1, mk(27'h1000000, 8'd0,   1'b0, 1'b1), 0, 1'b0);
    run_op(24'h000001, 24'h800001, 9'd30,   1'b0, mk(27'h4000008, 8'd7,   1'b0, 1'b0), 0, 1'b0);
    run_op(24'h000001, 24'h000003, 9'd30,   1'b0, mk(27'h0000300, 8'd0,   1'b0, 1'b1), 0, 1'b0);
    run_op(24'h000001, 24'h000007, 9'd3,    1'b0, mk(27'h0000001, 8'd0,   1'b0, 1'b1), 0, 1'b0);
    run_op(24'h800001, 24'h800000, 9'h1FD,  1'b1, mk(27'h0400001, 8'd0,   1'b0, 1'b1), 0, 1'b0);
    run_op(24'hC00000, 24'hC00000, 9'h000,  1'b1, mk(27'h4800000, 8'd1,   1'b0, 1'b0), 0, 1'b0);
    run_op(24'h800000, 24'h800000, 9'h1E0,  1'b1, mk(27'h0000001, 8'd0,   1'b0, 1'b1), 0, 1'b0);
    run_op(24'h000000, 24'h800000, 9'd127,  1'b0, mk(27'h0000000, 8'd0,   1'b0, 1'b0), 0, 1'b0);

    run_op(24'hC00000, 24'h800000, 9'd100,  1'b0, mk(27'h6000000, 8'd100, 1'b0, 1'b0), 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_sig", 32'(mul_proNorm_sig), 32'(last_res.sig));
    chk("hold_exp", 32'(mul_proNorm_exp), 32'(last_res.ex));

    // extra starts while busy must neither restart nor queue an operation
    run_op(24'hC00000, 24'hC00000, 9'd127,  1'b0, mk(27'h4800000, 8'd128, 1'b0, 1'b0), 5, 1'b1);
    repeat (30) @(posedge clk);
    #1;
    chk("rdy_count_busy", 32'(n_rdy), 32'(n_ops));

    @(posedge clk); #1;
    sig_A = 24'hC00000; sig_B = 24'hC00000; preNorm_exp = 9'd127; is_exp_underFlow = 1'b0;
    mul_start = 1'b1;
    @(posedge clk); #1;
    mul_start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_sig", 32'(mul_proNorm_sig), 32'd0);
    chk("arst_exp", 32'(mul_proNorm_exp), 32'd0);
    chk("arst_of",  32'(OF_from_proNorm), 32'd0);
    chk("arst_uf",  32'(UF_from_proNorm), 32'd0);
    chk("arst_rdy", 32'(mul_rdy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (35) @(posedge clk);
    #1;
    chk("rdy_count_reset", 32'(n_rdy), 32'(n_ops));
    run_op(24'h800000, 24'h800000, 9'd127, 1'b0, mk(27'h4000000, 8'd127, 1'b0, 1'b0), 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      case (i % 3)
        0: run_m({1'b1, 23'($urandom)}, {1'b1, 23'($urandom)}, 9'($urandom_range(1, 254)), 1'b0);
        1: run_m({1'b1, 23'($urandom)}, {1'b1, 23'($urandom)}, 9'(-$urandom_range(0, 30)), 1'b1);
        default: run_m(24'($urandom_range(1, 65535)), {1'b1, 23'($urandom)},
                       9'($urandom_range(1, 60)), 1'b0);
      endcase
    end

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("rdy_count_final", 32'(n_rdy), 32'(n_ops));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
